// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes over back-to-back windows and emits per-window rates on valid/ready.
// Optional decaying spike trace enabled by defining SPIKE_TRACE_EN.
module spike_rate_decoder #(
   parameter int n_stage     = 6,
   parameter int window_bits = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   spike_in,
   input  logic [window_bits-1:0] window,
   input  logic [2:0]             shift,
   output logic [n_stage+1:0]     rate_out,
   output logic                   rate_overflow,
   output logic                   rate_valid,
   input  logic                   rate_ready,
   output logic                   dropped,
   output logic [n_stage+1:0]     trace_out
);
   localparam int w = n_stage + 2;
   localparam logic [0:0] st_idle  = 1'b0;
   localparam logic [0:0] st_count = 1'b1;
   logic [0:0]             state;
   logic [w-1:0]           cnt, cnt_nxt;
   logic [window_bits-1:0] cyc, win_q;
   logic                   ovf, ovf_nxt, win_end, hold, clear;
   always_comb begin
      cnt_nxt = (spike_in && !(&cnt)) ? cnt + 1'b1 : cnt;
      ovf_nxt = ovf | (spike_in & (&cnt));
      win_end = state == st_count && enable && cyc == win_q;
      hold    = rate_valid && !rate_ready;
      clear   = state == st_idle || !enable || win_end;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= st_idle;
         cnt           <= '0;
         cyc           <= '0;
         win_q         <= '0;
         ovf           <= 1'b0;
         rate_out      <= '0;
         rate_overflow <= 1'b0;
         rate_valid    <= 1'b0;
         dropped       <= 1'b0;
      end else begin
         dropped <= win_end && hold;
         // a window end coinciding with a transfer reloads instead of dropping
         if (win_end && !hold) begin
            rate_out      <= cnt_nxt;
            rate_overflow <= ovf_nxt;
            rate_valid    <= 1'b1;
         end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
         end
         state <= enable ? st_count : st_idle;
         if ((state == st_idle && enable) || win_end) win_q <= window;
         cnt <= clear ? '0 : cnt_nxt;
         ovf <= clear ? 1'b0 : ovf_nxt;
         cyc <= clear ? '0 : cyc + 1'b1;
      end
   end
`ifdef SPIKE_TRACE_EN
   localparam logic [w:0] spk_inc = (w+1)'(2**n_stage);
   logic [w-1:0] trace, decay;
   logic [w:0]   tsum;
   always_comb begin
      decay = (shift == 3'd0) ? '0 : trace >> shift;
      tsum  = {1'b0, trace} - {1'b0, decay} + (spike_in ? spk_inc : '0);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) trace <= '0;
      else if (state == st_count) trace <= tsum[w] ? '1 : tsum[w-1:0];
   end
   assign trace_out = trace;
`else
   logic unused_shift;
   assign unused_shift = ^shift;
   assign trace_out = '0;
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: vector table plus directed sequences, results checked through a scoreboard queue.
module tb_spike_rate_decoder;
   logic       clk = 1'b0, reset, enable, spike_in, rate_ready;
   logic [7:0] window, rate_out, trace_out;
   logic [2:0] shift;
   logic       rate_overflow, rate_valid, dropped;
   typedef struct {logic [7:0] w; logic [255:0] spk; int r; logic o;} vec_t;
   typedef struct {logic [7:0] r; logic o;} exp_t;
   vec_t vecs[9];
   exp_t q[$];
   exp_t e_m;
   int   n_tests = 0, n_fail = 0;
   bit   sb_on = 0;

   spike_rate_decoder dut (
      .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .window(window),
      .shift(shift), .rate_out(rate_out), .rate_overflow(rate_overflow), .rate_valid(rate_valid),
      .rate_ready(rate_ready), .dropped(dropped), .trace_out(trace_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] r, input logic o);
      exp_t e;
      e.r = r;
      e.o = o;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb_on && rate_valid && rate_ready) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: rate_out=%0d ovf=%0d with no result expected", rate_out, rate_overflow);
         end else begin
            e_m = q.pop_front();
            if (rate_out !== e_m.r || rate_overflow !== e_m.o) begin
               n_fail++;
               $display("FAIL sb_rate: got %0d/%0d expected %0d/%0d", rate_out, rate_overflow, e_m.r, e_m.o);
            end
         end
      end
   end

   task automatic run_vec(input vec_t v);
      window = v.w;
      enable = 1'b1;
      spike_in = 1'b0;
      tick();
      for (int i = 0; i <= int'(v.w); i++) begin
         spike_in = v.spk[i];
         if (i == int'(v.w)) push(8'(v.r), v.o);
         tick();
      end
      enable = 1'b0;
      spike_in = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int drops, bad;
      vecs[0] = '{8'd9,   256'h92, 3, 1'b0};
      vecs[1] = '{8'd0,   256'h1, 1, 1'b0};
      vecs[2] = '{8'd0,   256'h0, 0, 1'b0};
      vecs[3] = '{8'd3,   256'hF, 4, 1'b0};
      vecs[4] = '{8'd255, {256{1'b1}}, 255, 1'b1};
      vecs[5] = '{8'd255, 256'h0, 0, 1'b0};
      vecs[6] = '{8'd254, {256{1'b1}}, 255, 1'b0};
      vecs[7] = '{8'd7,   256'hA5, 4, 1'b0};
      vecs[8] = '{8'd1,   256'h2, 1, 1'b0};
      reset = 1'b1; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; window = '0; shift = '0;
      tick();
      tick();
      chk("rst_rate", rate_out, 0);
      chk("rst_ovf", rate_overflow, 0);
      chk("rst_valid", rate_valid, 0);
      chk("rst_dropped", dropped, 0);
      chk("rst_trace", trace_out, 0);
      reset = 1'b0;
      tick();
      sb_on = 1; rate_ready = 1'b1;
      for (int v = 0; v < 9; v++) run_vec(vecs[v]);
      // back-to-back W=9 windows, spikes on cycles 0,5,9
      window = 8'd9; enable = 1'b1; tick();
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 10; i++) begin
            spike_in = (i == 0 || i == 5 || i == 9);
            if (i == 9) push(8'd3, 1'b0);
            tick();
            if (n == 0 && i == 8) chk("b2b_early_valid", rate_valid, 0);
            if (n == 0 && i == 9) chk("b2b_latency_valid", rate_valid, 1);
         end
      end
      enable = 1'b0; spike_in = 1'b0; tick(); tick();
      // W=0 with continuous ready: valid never drops, no drops
      window = 8'd0; enable = 1'b1; tick();
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         spike_in = 1'($urandom_range(0, 1));
         push({7'd0, spike_in}, 1'b0);
         tick();
         if (rate_valid !== 1'b1 || dropped !== 1'b0) bad++;
      end
      chk("w0_continuous", bad, 0);
      chk("trace_state", trace_out, 0);
      enable = 1'b0; spike_in = 1'b0; tick(); tick();
      // abort mid-window, then a fresh window must start from zero
      window = 8'd9; enable = 1'b1; tick();
      spike_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      enable = 1'b0; spike_in = 1'b0; tick(); tick();
      chk("abort_no_valid", rate_valid, 0);
      window = 8'd2; enable = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) push(8'd0, 1'b0);
         tick();
      end
      enable = 1'b0; tick(); tick();
      // window change mid-window applies only to the next window
      window = 8'd4; enable = 1'b1; tick();
      spike_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) window = 8'd1;
         if (i == 4) push(8'd5, 1'b0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         if (i == 1) push(8'd2, 1'b0);
         tick();
      end
      enable = 1'b0; spike_in = 1'b0; tick(); tick();
      chk("sb_drain", q.size(), 0);
      sb_on = 0;
      // backpressure W=3: first result held, two later windows dropped
      rate_ready = 1'b0; window = 8'd3; enable = 1'b1; tick();
      drops = 0; bad = 0;
      for (int c = 0; c < 12; c++) begin
         spike_in = (c < 4);
         tick();
         if (dropped === 1'b1) drops++;
         if (c >= 3 && (rate_out !== 8'd4 || rate_valid !== 1'b1)) bad++;
         if (c == 7) chk("bp_drop_timing", dropped, 1);
      end
      chk("bp_drops", drops, 2);
      chk("bp_hold", bad, 0);
      spike_in = 1'b0; enable = 1'b0; rate_ready = 1'b1;
      tick();
      chk("bp_xfer_valid", rate_valid, 0);
      chk("bp_keep_rate", rate_out, 4);
      chk("bp_drop_clear", dropped, 0);
      tick();
      // asynchronous reset with a pending result
      rate_ready = 1'b0; window = 8'd1; enable = 1'b1; tick();
      spike_in = 1'b1; tick(); tick();
      spike_in = 1'b0;
      chk("pend_valid", rate_valid, 1);
      chk("pend_rate", rate_out, 2);
      #2 reset = 1'b1;
      #1;
      chk("arst_rate", rate_out, 0);
      chk("arst_valid", rate_valid, 0);
      enable = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("arst_after_valid", rate_valid, 0);
`ifdef SPIKE_TRACE_EN
      rate_ready = 1'b1; shift = 3'd1; window = 8'd255; enable = 1'b1; tick();
      spike_in = 1'b1; tick();
      spike_in = 1'b0;
      chk("trace_0", trace_out, 64);
      for (int k = 1; k < 7; k++) begin
         tick();
         chk("trace_decay", trace_out, 64 >> k);
      end
      enable = 1'b0; tick(); tick();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
